// File: rtl/axi_cmd_queue.sv
// Command front-end: edge-detects the core's control register, queues commands,
// issues them one at a time to the AXI-Lite master and tracks completion status.
module axi_cmd_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                       aclk,
    input  logic                       areset_n,
    input  logic [31:0]                i_axi_addr_reg,
    input  logic [31:0]                i_axi_data_reg,
    input  logic                       i_axi_sel_reg,
    input  logic [3:0]                 i_axi_strobe_reg,
    input  logic [1:0]                 i_axi_control_reg,
    input  logic                       i_done,
    input  logic                       i_err,
    input  logic [31:0]                i_rdata,
    input  logic                       i_clr,
    output logic                       start_write,
    output logic                       start_read,
    output logic [31:0]                o_addr,
    output logic [31:0]                o_data,
    output logic [3:0]                 o_wstrb,
    output logic                       o_psel,
    output logic                       o_busy,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic [31:0]                o_rdata,
    output logic                       o_rdata_valid,
    output logic                       o_err_sticky,
    output logic                       o_timeout,
    output logic [7:0]                 o_drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic        is_read;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strobe;
        logic        sel;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    cmd_t          mem [DEPTH];
    cmd_t          push_cmd;
    cmd_t          head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    prev_ctrl;
    logic [1:0]    rise;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          cur_read;
    logic [1:0]    drops;
    logic [7:0]    drop_base;
    logic [8:0]    drop_sum;
    logic [TW-1:0] wait_cnt;

    assign rise    = i_axi_control_reg & ~prev_ctrl;
    assign head    = mem[rd_ptr];
    assign o_full  = (o_count == CW'(DEPTH));
    assign o_empty = (o_count == '0);
    assign o_busy  = !o_empty || (state != IDLE);

    // A write edge takes priority; a simultaneous read edge is counted as a drop.
    always_comb begin
        push_req        = |rise;
        push            = push_req && !o_full;
        pop             = (state == IDLE) && !o_empty;
        push_cmd.is_read = !rise[0];
        push_cmd.addr   = i_axi_addr_reg;
        push_cmd.data   = i_axi_data_reg;
        push_cmd.strobe = i_axi_strobe_reg;
        push_cmd.sel    = i_axi_sel_reg;
        drops           = {1'b0, (rise == 2'b11)} + {1'b0, (push_req && o_full)};
        drop_base       = i_clr ? 8'd0 : o_drop_cnt;
        drop_sum        = {1'b0, drop_base} + {7'd0, drops};
    end

    // NOTE: the storage array has no reset; an entry is only read after it was
    // written, so the reset pointers and count are enough to make it valid.
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= push_cmd;
    end

    // NOTE: all state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            o_count   <= '0;
            prev_ctrl <= '0;
        end else begin
            prev_ctrl <= i_axi_control_reg;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   o_count <= o_count + CW'(1);
                2'b01:   o_count <= o_count - CW'(1);
                default: o_count <= o_count;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state         <= IDLE;
            start_write   <= 1'b0;
            start_read    <= 1'b0;
            o_addr        <= '0;
            o_data        <= '0;
            o_wstrb       <= '0;
            o_psel        <= 1'b0;
            cur_read      <= 1'b0;
            wait_cnt      <= '0;
            o_rdata       <= '0;
            o_rdata_valid <= 1'b0;
            o_err_sticky  <= 1'b0;
            o_timeout     <= 1'b0;
            o_drop_cnt    <= '0;
        end else begin
            start_write <= 1'b0;
            start_read  <= 1'b0;
            // Clears come first so a set event later in this block wins.
            if (i_clr) begin
                o_rdata_valid <= 1'b0;
                o_err_sticky  <= 1'b0;
                o_timeout     <= 1'b0;
            end
            o_drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
            case (state)
                IDLE: begin
                    if (pop) begin
                        o_addr      <= head.addr;
                        o_data      <= head.data;
                        o_wstrb     <= head.strobe;
                        o_psel      <= head.sel;
                        cur_read    <= head.is_read;
                        start_write <= !head.is_read;
                        start_read  <= head.is_read;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (i_done) begin
                        state <= IDLE;
                        if (cur_read) begin
                            o_rdata       <= i_rdata;
                            o_rdata_valid <= 1'b1;
                        end
                        if (i_err) o_err_sticky <= 1'b1;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        o_timeout <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi_cmd_queue.md
# axi_cmd_queue

Command front-end between the RISC-V core's memory-mapped AXI register outputs and the AXI-Lite master. It turns rising edges of the core's 2-bit control register into queued transaction commands, buffering up to `DEPTH` of them. It issues them one at a time as single-cycle `start_write`/`start_read` pulses, with a stable address/data/strobe/select payload. It tracks completion, read data, errors and timeouts in status outputs the core polls.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `TIMEOUT`, 1024: cycles in WAIT without `i_done` before the command is abandoned.
- `aclk` in 1: clock. One clock; all logic is on the rising edge.
- `areset_n` in 1: reset, synchronous, active-low.
- `i_axi_addr_reg` in 32: command address from the core.
- `i_axi_data_reg` in 32: write data from the core.
- `i_axi_sel_reg` in 1: APB slave select bit from the core.
- `i_axi_strobe_reg` in 4: write strobes from the core.
- `i_axi_control_reg` in 2: level control from the core; bit 0 = write request, bit 1 = read request.
- `i_done` in 1: single-cycle completion pulse from the AXI-Lite master.
- `i_err` in 1: error response; valid with `i_done`.
- `i_rdata` in 32: read data; valid with `i_done`.
- `i_clr` in 1: clears the sticky status bits and `o_drop_cnt`.
- `start_write`, `start_read` out 1: single-cycle issue pulses to the master.
- `o_addr` out 32, `o_data` out 32, `o_wstrb` out 4, `o_psel` out 1: payload of the issued command.
- `o_busy` out 1: FIFO non-empty or FSM not IDLE.
- `o_full`, `o_empty` out 1: FIFO status.
- `o_count` out $clog2(DEPTH+1): number of FIFO entries.
- `o_rdata` out 32, `o_rdata_valid` out 1: last captured read data and its sticky valid flag.
- `o_err_sticky`, `o_timeout` out 1: sticky error flag and sticky timeout flag.
- `o_drop_cnt` out 8: count of rejected requests; saturates at 255.

## Operation
- **Edge detect:** `i_axi_control_reg` is registered each cycle. A request exists where a control bit is 1 now and was 0 in the previous cycle. Holding a bit high produces no further requests.
- **Enqueue:** a request pushes {type, addr, data, strobe, sel}, sampled in the same cycle as the edge.
- **Both edges in one cycle:** the write is enqueued; the read is dropped and `o_drop_cnt` increments.
- **FIFO full:** the push is dropped and `o_drop_cnt` increments. Fullness is judged on the pre-pop count, so a pop in the same cycle does not make room.
- **FSM states:** IDLE, ISSUE, WAIT.
- IDLE → ISSUE when the FIFO is non-empty. The head entry is popped into the issue registers (`o_addr`, `o_data`, `o_wstrb`, `o_psel`, type).
- ISSUE → WAIT always. Exactly one of `start_write`/`start_read` is high, selected by type.
- **WAIT on `i_done`:** go to IDLE. If the command was a read, `o_rdata`←`i_rdata` and set `o_rdata_valid`. If `i_err` is high, set `o_err_sticky`; on an errored read, `o_rdata` is still captured.
- **WAIT timeout:** the WAIT cycle counter reaches TIMEOUT-1 without `i_done` → set `o_timeout` and go to IDLE. The command is discarded.
- A late `i_done` that arrives in IDLE or ISSUE is ignored.
- **`i_clr`:** clears `o_rdata_valid`, `o_err_sticky`, `o_timeout` and `o_drop_cnt`. A set event in the same cycle wins over the clear.
- **Reset:** all outputs, FIFO pointers, the count, the previous-control register and the FSM return to reset values. If reset hits mid-transaction, the FSM returns to IDLE without a pulse.

## Timing
- **Reset values:**
  - all outputs 0, except `o_empty`=1;
  - FSM IDLE;
  - previous-control register 0. A control bit already held high when reset is released therefore counts as an edge on the first cycle.
- **Latency:** edge in cycle 0 → `o_count` updates in cycle 1 → pop in cycle 1 → start pulse and valid payload in cycle 2 → WAIT from cycle 3.
- **Payload hold:** the payload stays stable from the pulse until the next ISSUE.
- **Issue rate:** back-to-back commands are at least 3 cycles apart (IDLE, ISSUE, WAIT with `i_done` in the first WAIT cycle).
- **Pointers and count:**
  - read/write pointers are $clog2(DEPTH) bits and wrap naturally;
  - `o_count` increments on a push alone, decrements on a pop alone, and is unchanged on a simultaneous push and pop;
  - `o_full` = (count==DEPTH), `o_empty` = (count==0).
- **Timeout counter:** 0 on entering WAIT; the timeout fires in WAIT cycle TIMEOUT.

## Test plan
- **Single write:** control 00→01 with addr 0x1000_0004, data 0xA5, strobe 0xF → `start_write`=1 in cycle 2 only, `o_addr`=0x1000_0004; `i_done` → `o_busy`=0.
- **Single read:** control 00→10, `i_done` with `i_rdata`=0xDEAD_BEEF → `o_rdata`=0xDEAD_BEEF, `o_rdata_valid`=1; after `i_clr`, `o_rdata_valid`=0.
- **Overflow:** stall `i_done`, create 6 edges with DEPTH=4 → `o_full`=1 and `o_drop_cnt`=1 (one command is in WAIT, 4 are queued). Complete all → 5 start pulses in FIFO order.
- **Simultaneous edges:** control 00→11 → exactly one `start_write`, no `start_read`, `o_drop_cnt`=1.
- **Timeout:** issue a read, never pulse `i_done` → `o_timeout`=1 exactly TIMEOUT cycles after entering WAIT; a queued next command then issues normally.
- **Reset mid-WAIT:** assert `areset_n`=0 for 1 cycle → `o_count`=0, no pulses afterwards, all status 0; a later `i_done` has no effect.
